alu_secuencial: RTL and testbench

Parametrised, registered arithmetic-logic unit with a valid/ready input handshake and a registered output. It computes the same ten operations as the team's existing combinational result selector, at any data width. Multiplication, division and modulo are multi-cycle iterative operations; all other operations complete in one cycle. Status flags and an error flag are registered with each result. It sits between the operand/selection front end (switches/registers) and the display/result path of the lab datapath.

---
 rtl/alu_secuencial_if.sv | 23 ++
 rtl/alu_secuencial.sv | 139 +++++++++++++
 tb/tb_alu_secuencial.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/alu_secuencial_if.sv
// alu_if: handshake, operand and result bus of alu_secuencial
// master drives operands/seleccion/entrada_valida; slave returns listo and the registered result.
interface alu_if #(
    parameter int ANCHO = 4
);
    logic             entrada_valida;
    logic             listo;
    logic [ANCHO-1:0] operando_a;
    logic [ANCHO-1:0] operando_b;
    logic [3:0]       seleccion;
    logic [ANCHO-1:0] salida;
    logic             salida_valida;
    logic [3:0]       banderas;
    logic             error_op;
    modport master (
        output entrada_valida, operando_a, operando_b, seleccion,
        input  listo, salida, salida_valida, banderas, error_op
    );
    modport slave (
        input  entrada_valida, operando_a, operando_b, seleccion,
        output listo, salida, salida_valida, banderas, error_op
    );
endinterface

// File: rtl/alu_secuencial.sv
// alu_secuencial: registered ALU with valid/ready input and iterative mul/div/mod
// Ports: reloj (rising edge), reset_n (async, active low), bus (alu_if.slave):
// entrada_valida/listo handshake, operando_a/b, seleccion, and the registered
// salida, salida_valida pulse, banderas {N,Z,C,V} and error_op.
module alu_secuencial #(
    parameter int ANCHO = 4
) (
    input logic  reloj,
    input logic  reset_n,
    alu_if.slave bus
);
    localparam int CW = $clog2(ANCHO);
    typedef enum logic [1:0] {LIBRE, CALCULO, CIERRE} estado_t;
    estado_t            estado_q, estado_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*ANCHO-1:0] acc_q, acc_d, mc_q, mc_d;
    logic [ANCHO-1:0]   mb_q, mb_d, salida_q, salida_d;
    logic [3:0]         op_q, op_d, banderas_q, banderas_d;
    logic               error_q, error_d, valida_q, valida_d;
    logic [ANCHO-1:0]   a, b, res, r_n;
    logic [ANCHO:0]     suma, resta, r_sh;
    logic               c, v, err, ge, multi, fin;
    assign a = bus.operando_a;
    assign b = bus.operando_b;
    always_comb begin
        suma  = {1'b0, a} + {1'b0, b};
        resta = {1'b0, a} - {1'b0, b};
        // restoring division: acc holds {remainder, dividend/quotient}, divisor in mb
        r_sh  = {acc_q[2*ANCHO-1:ANCHO], acc_q[ANCHO-1]};
        ge    = r_sh >= {1'b0, mb_q};
        r_n   = r_sh[ANCHO-1:0] - mb_q;
        multi = bus.seleccion inside {4'b0010, 4'b0011, 4'b0100};
        res   = '0;
        c     = 1'b0;
        v     = 1'b0;
        err   = 1'b0;
        // in CIERRE the captured opcode selects the iterative result, otherwise the live input
        case (estado_q == CIERRE ? op_q : bus.seleccion)
            4'b0000: begin
                res = suma[ANCHO-1:0];
                c   = suma[ANCHO];
                v   = (a[ANCHO-1] == b[ANCHO-1]) && (suma[ANCHO-1] != a[ANCHO-1]);
            end
            4'b0001: begin
                res = resta[ANCHO-1:0];
                c   = resta[ANCHO];
                v   = (a[ANCHO-1] != b[ANCHO-1]) && (resta[ANCHO-1] != a[ANCHO-1]);
            end
            4'b0010: begin
                res = acc_q[ANCHO-1:0];
                c   = |acc_q[2*ANCHO-1:ANCHO];
            end
            4'b0011: begin
                res = acc_q[ANCHO-1:0];
                err = ~|mb_q;
            end
            4'b0100: begin
                res = acc_q[2*ANCHO-1:ANCHO];
                err = ~|mb_q;
            end
            4'b0101: res = a & b;
            4'b0110: res = a | b;
            4'b0111: res = a ^ b;
            4'b1000: res = a << b;
            4'b1001: res = a >> b;
            default: err = 1'b1;
        endcase
        fin        = estado_q == CIERRE || (estado_q == LIBRE && bus.entrada_valida && !multi);
        estado_d   = estado_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        mc_d       = mc_q;
        mb_d       = mb_q;
        op_d       = op_q;
        salida_d   = salida_q;
        banderas_d = banderas_q;
        error_d    = error_q;
        valida_d   = 1'b0;
        if (estado_q == LIBRE && bus.entrada_valida && multi) begin
            estado_d = CALCULO;
            cnt_d    = '0;
            acc_d    = bus.seleccion == 4'b0010 ? '0 : {{ANCHO{1'b0}}, a};
            mc_d     = {{ANCHO{1'b0}}, a};
            mb_d     = b;
            op_d     = bus.seleccion;
        end
        if (estado_q == CALCULO) begin
            if (op_q == 4'b0010) begin
                acc_d = acc_q + (mb_q[0] ? mc_q : '0);
                mc_d  = mc_q << 1;
                mb_d  = mb_q >> 1;
            end else begin
                acc_d = {ge ? r_n : r_sh[ANCHO-1:0], acc_q[ANCHO-2:0], ge};
            end
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(ANCHO - 1)) begin
                cnt_d    = '0;
                estado_d = CIERRE;
            end
        end
        if (estado_q == CIERRE) estado_d = LIBRE;
        if (fin) begin
            salida_d   = res;
            banderas_d = {res[ANCHO-1], res == '0, c, v};
            error_d    = err;
            valida_d   = 1'b1;
        end
    end
    always_ff @(posedge reloj or negedge reset_n) begin
        if (!reset_n) begin
            estado_q   <= LIBRE;
            cnt_q      <= '0;
            acc_q      <= '0;
            mc_q       <= '0;
            mb_q       <= '0;
            op_q       <= '0;
            salida_q   <= '0;
            banderas_q <= '0;
            error_q    <= 1'b0;
            valida_q   <= 1'b0;
        end else begin
            estado_q   <= estado_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            mc_q       <= mc_d;
            mb_q       <= mb_d;
            op_q       <= op_d;
            salida_q   <= salida_d;
            banderas_q <= banderas_d;
            error_q    <= error_d;
            valida_q   <= valida_d;
        end
    end
    assign bus.listo         = estado_q == LIBRE;
    assign bus.salida        = salida_q;
    assign bus.salida_valida = valida_q;
    assign bus.banderas      = banderas_q;
    assign bus.error_op      = error_q;
endmodule

// File: tb/tb_alu_secuencial.sv
// tb_alu_secuencial: directed scoreboard bench for alu_secuencial
module tb_alu_secuencial;
    localparam int W = 4;
    logic reloj = 1'b0;
    logic reset_n = 1'b0;
    logic valida_vista = 1'b0;
    int errors = 0;
    int checks = 0;
    logic [W+4:0] exp_q[$];
    string tag_q[$];
    alu_if #(.ANCHO(W)) bus();
    alu_secuencial #(.ANCHO(W)) dut (
        .reloj(reloj),
        .reset_n(reset_n),
        .bus(bus)
    );
    always #5 reloj = ~reloj;
    initial begin
        #200000;
        $display("FAIL watchdog: observed=running expected=finished");
        $fatal(1, "watchdog");
    end
    function automatic logic [W+4:0] model(input logic [3:0] sel, input logic [W-1:0] a, input logic [W-1:0] b);
        int ua, ub, sa, sb, r;
        logic [W-1:0] s;
        logic c, v, e;
        ua = int'(a);
        ub = int'(b);
        sa = a[W-1] ? ua - (1 << W) : ua;
        sb = b[W-1] ? ub - (1 << W) : ub;
        c = 1'b0;
        v = 1'b0;
        e = 1'b0;
        r = 0;
        case (sel)
            4'd0: begin
                r = ua + ub;
                c = r >= (1 << W);
                v = (sa + sb) >= (1 << (W - 1)) || (sa + sb) < -(1 << (W - 1));
            end
            4'd1: begin
                r = ua - ub;
                c = ua < ub;
                v = (sa - sb) >= (1 << (W - 1)) || (sa - sb) < -(1 << (W - 1));
            end
            4'd2: begin
                r = ua * ub;
                c = r >= (1 << W);
            end
            4'd3: if (ub == 0) begin r = (1 << W) - 1; e = 1'b1; end else r = ua / ub;
            4'd4: if (ub == 0) begin r = ua; e = 1'b1; end else r = ua % ub;
            4'd5: r = ua & ub;
            4'd6: r = ua | ub;
            4'd7: r = ua ^ ub;
            4'd8: r = ub >= W ? 0 : ua << ub;
            4'd9: r = ub >= W ? 0 : ua >> ub;
            default: e = 1'b1;
        endcase
        s = r[W-1:0];
        return {s, s[W-1], s == '0, c, v, e};
    endfunction
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask
    task automatic paso();
        string t;
        @(negedge reloj);
        valida_vista = bus.salida_valida;
        if (bus.salida_valida) begin
            if (exp_q.size() == 0) chk("valida_sin_operacion", 32'(bus.salida_valida), 0);
            else begin
                t = tag_q.pop_front();
                chk(t, {bus.salida, bus.banderas, bus.error_op}, exp_q.pop_front());
            end
        end
    endtask
    task automatic op(input logic [3:0] sel, input logic [W-1:0] a, input logic [W-1:0] b, input bit push, input string tag);
        bus.entrada_valida = 1'b1;
        bus.seleccion = sel;
        bus.operando_a = a;
        bus.operando_b = b;
        if (push) begin
            exp_q.push_back(model(sel, a, b));
            tag_q.push_back(tag);
        end
        paso();
        bus.entrada_valida = 1'b0;
        bus.operando_a = ~a;
        bus.operando_b = ~b;
        bus.seleccion = 4'b0000;
    endtask
    task automatic multi(input logic [3:0] sel, input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
        int n;
        n = 0;
        op(sel, a, b, 1'b1, tag);
        while (!bus.salida_valida && n < 40) begin
            paso();
            n++;
        end
        chk({tag, "_latencia"}, n, W + 1);
    endtask
    initial begin
        int n, bajo, vistos;
        logic [3:0] s;
        bus.entrada_valida = 1'b0;
        bus.seleccion = '0;
        bus.operando_a = '0;
        bus.operando_b = '0;
        repeat (3) @(negedge reloj);
        reset_n = 1'b1;
        @(negedge reloj);
        chk("rst_salida", bus.salida, 0);
        chk("rst_banderas", bus.banderas, 0);
        chk("rst_error", bus.error_op, 0);
        chk("rst_valida", bus.salida_valida, 0);
        chk("rst_listo", bus.listo, 1);
        op(4'd0, 4'b0111, 4'b1001, 1'b1, "suma");
        chk("suma_valida_1ciclo", valida_vista, 1);
        op(4'd1, 4'b0011, 4'b0101, 1'b1, "resta");
        op(4'd7, 4'b1010, 4'b0110, 1'b1, "xor_b2b");
        chk("xor_valida_b2b", valida_vista, 1);
        paso();
        chk("valida_un_ciclo", bus.salida_valida, 0);
        op(4'd2, 4'b0110, 4'b0011, 1'b1, "mult");
        n = 0;
        bajo = 0;
        while (!bus.salida_valida && n < 40) begin
            if (!bus.listo) bajo++;
            bus.entrada_valida = n[0];
            bus.seleccion = 4'd0;
            bus.operando_a = 4'd1;
            bus.operando_b = 4'd1;
            paso();
            n++;
        end
        bus.entrada_valida = 1'b0;
        chk("mult_latencia", n, 5);
        chk("mult_listo_bajo", bajo, 5);
        chk("mult_listo_en_valida", bus.listo, 1);
        paso();
        chk("mult_retiene_salida", bus.salida, 4'b0010);
        chk("mult_valida_pulso", bus.salida_valida, 0);
        multi(4'd3, 4'b1101, 4'b0100, "div");
        multi(4'd4, 4'b1101, 4'b0100, "mod");
        multi(4'd3, 4'b1001, 4'b0000, "div_cero");
        op(4'b1100, 4'd5, 4'd3, 1'b1, "invalido");
        chk("invalido_1ciclo", valida_vista, 1);
        op(4'd8, 4'b0011, 4'd2, 1'b1, "shl");
        op(4'd9, 4'b1000, 4'd5, 1'b1, "shr_grande");
        op(4'd5, 4'b1111, 4'b1011, 1'b1, "and");
        op(4'd3, 4'b1101, 4'b0100, 1'b0, "abortada");
        paso();
        paso();
        reset_n = 1'b0;
        #1;
        chk("abort_salida", bus.salida, 0);
        chk("abort_banderas", bus.banderas, 0);
        chk("abort_error", bus.error_op, 0);
        chk("abort_listo", bus.listo, 1);
        @(negedge reloj);
        reset_n = 1'b1;
        vistos = 0;
        for (int i = 0; i < 8; i++) begin
            paso();
            if (bus.salida_valida) vistos++;
        end
        chk("abort_sin_valida", vistos, 0);
        multi(4'd2, 4'b1111, 4'b1111, "mult_post_reset");
        for (int i = 0; i < 12; i++) begin
            s = 4'($urandom_range(0, 15));
            if (s inside {4'd2, 4'd3, 4'd4}) multi(s, 4'($urandom), 4'($urandom), $sformatf("azar%0d", i));
            else op(s, 4'($urandom), 4'($urandom), 1'b1, $sformatf("azar%0d", i));
        end
        paso();
        chk("cola_vacia", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
